// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: synchronised four-mode SPI receiver feeding a show-ahead valid/ready FIFO
module spi_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          cipo_raw,
  input  logic                          dclk_raw,
  input  logic                          cs_n_raw,
  input  logic                          cpol_in,
  input  logic                          cpha_in,
  input  logic                          msb_first_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid_out,
  input  logic                          data_ready_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          overflow_out,
  output logic                          abort_out,
  input  logic                          clear_in
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] dclk_s, cs_s, cipo_s;
  logic dclk, cs, cipo, dclk_d, cs_d;
  logic dclk_rise, dclk_fall, cs_fall, cs_rise, sample;
  logic [2:0] mode, mode_n;
  logic [DATA_WIDTH-1:0] sr, sr_n;
  logic [BW-1:0] cnt, cnt_n;
  logic push, abort_n, pop, full, wr_en;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  assign dclk = dclk_s[SYNC_STAGES-1];
  assign cs = cs_s[SYNC_STAGES-1];
  assign cipo = cipo_s[SYNC_STAGES-1];
  assign dclk_rise = dclk & ~dclk_d;
  assign dclk_fall = ~dclk & dclk_d;
  assign cs_fall = ~cs & cs_d;
  assign cs_rise = cs & ~cs_d;
  assign sample = (mode[2] ^ mode[1]) ? dclk_fall : dclk_rise;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dclk_s <= '0;
      cs_s <= '1;
      cipo_s <= '0;
      dclk_d <= 1'b0;
      cs_d <= 1'b1;
    end else begin
      dclk_s <= SYNC_STAGES'({dclk_s, dclk_raw});
      cs_s <= SYNC_STAGES'({cs_s, cs_n_raw});
      cipo_s <= SYNC_STAGES'({cipo_s, cipo_raw});
      dclk_d <= dclk;
      cs_d <= cs;
    end
  end
  always_comb begin
    state_n = state;
    mode_n = mode;
    sr_n = sr;
    cnt_n = cnt;
    push = 1'b0;
    abort_n = 1'b0;
    if (state == IDLE) begin
      if (cs_fall) begin
        state_n = ACTIVE;
        mode_n = {cpol_in, cpha_in, msb_first_in};
        sr_n = '0;
        cnt_n = '0;
      end
    end else begin
      if (sample) begin
        sr_n = mode[0] ? {sr[DATA_WIDTH-2:0], cipo} : {cipo, sr[DATA_WIDTH-1:1]};
        push = cnt == BW'(DATA_WIDTH - 1);
        cnt_n = push ? '0 : cnt + 1'b1;
      end
      if (cs_rise) begin
        state_n = IDLE;
        abort_n = cnt_n != '0;
      end
    end
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      mode <= '0;
      sr <= '0;
      cnt <= '0;
      abort_out <= 1'b0;
    end else begin
      state <= state_n;
      mode <= mode_n;
      sr <= sr_n;
      cnt <= cnt_n;
      abort_out <= abort_n;
    end
  end
  assign pop = data_valid_out & data_ready_in;
  assign full = count == CW'(FIFO_DEPTH);
  assign wr_en = push & (~full | pop);
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow_out <= 1'b0;
    end else if (clear_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= sr_n;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
      if (push && !wr_en) overflow_out <= 1'b1;
    end
  end
  assign data_out = mem[rd_ptr];
  assign data_valid_out = count != '0;
  assign fifo_count_out = count;
endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb_spi_rx_fifo: randomized SPI frames checked against a queue-based word model
module tb_spi_rx_fifo;
  localparam int W = 8;
  localparam int D = 8;
  localparam int S = 3;
  logic clk_in = 0, rst_in = 0, cipo_raw = 0, dclk_raw = 0, cs_n_raw = 1;
  logic cpol_in = 0, cpha_in = 0, msb_first_in = 1, data_ready_in = 0, clear_in = 0;
  logic [W-1:0] data_out;
  logic data_valid_out, overflow_out, abort_out;
  logic [$clog2(D):0] fifo_count_out;
  int n_chk = 0, n_pass = 0, cyc = 0, aborts = 0, vcycles = 0, a0 = 0;
  logic [W-1:0] exp_q[$];
  int samp_cyc[$], vrise[$];
  logic [W-1:0] wbuf[16];
  bit rand_rdy = 0;
  logic vprev = 0;
  spi_rx_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .cipo_raw(cipo_raw), .dclk_raw(dclk_raw),
    .cs_n_raw(cs_n_raw), .cpol_in(cpol_in), .cpha_in(cpha_in), .msb_first_in(msb_first_in),
    .data_out(data_out), .data_valid_out(data_valid_out), .data_ready_in(data_ready_in),
    .fifo_count_out(fifo_count_out), .overflow_out(overflow_out), .abort_out(abort_out),
    .clear_in(clear_in)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (abort_out) aborts++;
      if (data_valid_out) vcycles++;
      if (data_valid_out && !vprev) vrise.push_back(cyc);
      if (data_valid_out && data_ready_in) begin
        if (exp_q.size() > 0) chk("word", data_out, exp_q.pop_front());
        else chk("unexpected_pop", data_valid_out, 0);
      end
    end
    vprev = data_valid_out;
  end
  initial forever begin
    @(posedge clk_in);
    #1;
    if (rand_rdy) data_ready_in = 1'($urandom_range(0, 1));
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic send_bit(input bit cpol, input bit cpha, input bit b);
    if (!cpha) begin
      cipo_raw = b;
      cycles(4);
      dclk_raw = ~cpol;
      samp_cyc.push_back(cyc);
      cycles(2);
      cipo_raw = ~b;
      cycles(2);
      dclk_raw = cpol;
    end else begin
      dclk_raw = ~cpol;
      cycles(2);
      cipo_raw = b;
      cycles(2);
      dclk_raw = cpol;
      samp_cyc.push_back(cyc);
      cycles(2);
      cipo_raw = ~b;
      cycles(2);
    end
  endtask
  task automatic frame(input bit cpol, input bit cpha, input bit msb, input int nw,
                       input int extra, input bit raise);
    logic [W-1:0] w;
    int nb;
    cpol_in = cpol;
    cpha_in = cpha;
    msb_first_in = msb;
    dclk_raw = cpol;
    cs_n_raw = 1;
    cycles(6);
    for (int j = 0; j < nw; j++) exp_q.push_back(wbuf[j]);
    cs_n_raw = 0;
    cycles(6);
    for (int j = 0; j < nw + (extra > 0 ? 1 : 0); j++) begin
      w = j < nw ? wbuf[j] : W'($urandom);
      nb = j < nw ? W : extra;
      for (int i = 0; i < nb; i++) send_bit(cpol, cpha, msb ? w[W-1-i] : w[i]);
    end
    cycles(4);
    if (raise) begin
      cs_n_raw = 1;
      cycles(8);
    end
  endtask
  initial begin
    #1 rst_in = 1;
    #2;
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid_out, 0);
    chk("rst_count", fifo_count_out, 0);
    chk("rst_ovf", overflow_out, 0);
    chk("rst_abort", abort_out, 0);
    cycles(3);
    rst_in = 0;
    cycles(2);
    data_ready_in = 1;
    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h3C;
    samp_cyc.delete();
    vrise.delete();
    vcycles = 0;
    a0 = aborts;
    frame(0, 0, 1, 2, 0, 1);
    chk("t1_vcycles", vcycles, 2);
    chk("t1_latency", vrise[0] - samp_cyc[7] + 1, S + 2);
    chk("t1_abort", aborts - a0, 0);
    chk("t1_drained", exp_q.size(), 0);
    wbuf[0] = 8'hC2;
    frame(1, 1, 0, 1, 0, 1);
    wbuf[0] = 8'h81;
    frame(0, 1, 1, 1, 0, 1);
    frame(1, 0, 1, 1, 0, 1);
    chk("t3_drained", exp_q.size(), 0);
    data_ready_in = 0;
    for (int j = 0; j < 10; j++) wbuf[j] = W'(j + 1);
    frame(0, 0, 1, 10, 0, 1);
    while (exp_q.size() > D) void'(exp_q.pop_back());
    chk("t4_count", fifo_count_out, D);
    chk("t4_ovf", overflow_out, 1);
    chk("t4_head", data_out, 1);
    data_ready_in = 1;
    cycles(12);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_count0", fifo_count_out, 0);
    chk("t4_ovf_sticky", overflow_out, 1);
    clear_in = 1;
    cycles(1);
    clear_in = 0;
    chk("t4_ovf_clr", overflow_out, 0);
    a0 = aborts;
    frame(0, 0, 1, 0, 5, 1);
    chk("t5_abort", aborts - a0, 1);
    chk("t5_count", fifo_count_out, 0);
    wbuf[0] = 8'h5A;
    frame(0, 0, 1, 1, 0, 1);
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_abort_once", aborts - a0, 1);
    data_ready_in = 0;
    for (int j = 0; j < 3; j++) wbuf[j] = W'($urandom);
    frame(0, 0, 1, 3, 0, 1);
    chk("t6_count3", fifo_count_out, 3);
    frame(0, 0, 1, 0, 3, 0);
    #3 rst_in = 1;
    #1;
    chk("t6_valid", data_valid_out, 0);
    chk("t6_count", fifo_count_out, 0);
    chk("t6_data", data_out, 0);
    exp_q.delete();
    cs_n_raw = 1;
    cycles(3);
    rst_in = 0;
    cycles(2);
    data_ready_in = 1;
    wbuf[0] = 8'hF0;
    vcycles = 0;
    frame(0, 0, 1, 1, 0, 1);
    chk("t6_one_word", vcycles, 1);
    chk("t6_drained", exp_q.size(), 0);
    rand_rdy = 1;
    for (int f = 0; f < 20; f++) begin
      int nw, extra;
      nw = $urandom_range(1, 3);
      for (int j = 0; j < nw; j++) wbuf[j] = W'($urandom);
      extra = $urandom_range(0, 2) == 0 ? $urandom_range(1, W - 1) : 0;
      a0 = aborts;
      frame(1'($urandom), 1'($urandom), 1'($urandom), nw, extra, 1);
      chk("rnd_abort", aborts - a0, extra > 0 ? 1 : 0);
    end
    rand_rdy = 0;
    cycles(1);
    data_ready_in = 1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) cycles(1);
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_ovf", overflow_out, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
